// File: rtl/cache_defs_pkg.sv
// -----------------------------------------------------------------------------
// cache_defs_pkg
//  Shared definitions for the L1 caches, the L2 port arbiter and the
//  statistics logic: address/opcode widths, L2 opcodes, requester source
//  encoding and the arbiter FSM state type.
// -----------------------------------------------------------------------------
package cache_defs_pkg;

    localparam int ADDR_W = 26;   // line address, 64-byte lines
    localparam int OP_W   = 2;    // L2 opcode width

    localparam logic [OP_W-1:0] L2_READ  = 2'b00;
    localparam logic [OP_W-1:0] L2_WRITE = 2'b01;
    localparam logic [OP_W-1:0] L2_RFO   = 2'b10;

    localparam logic SRC_DC = 1'b0;
    localparam logic SRC_IC = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Map a one-hot grant vector (bit 0 = DC, bit 1 = IC) to a source id.
    function automatic logic gnt_to_src(input logic [1:0] gnt);
        logic src;
        if (gnt[1]) begin
            src = SRC_IC;
        end else begin
            src = SRC_DC;
        end
        return src;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//  Two-way round-robin arbiter. A lone requester wins; on a tie the requester
//  that did not win last time wins. The last-winner flop updates only when a
//  grant is actually issued, so a requester that drops out does not lose its
//  turn.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  req[1:0]     request vector, bit 0 = DC, bit 1 = IC
//  en           arbitration enabled (no grant when low)
//  gnt[1:0]     one-hot grant (combinational)
// -----------------------------------------------------------------------------
module rr_arb2
    import cache_defs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_gnt_q;
    logic last_gnt_d;

    // Grant selection and next value of the last-winner record.
    always_comb begin
        gnt        = 2'b00;
        last_gnt_d = last_gnt_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (last_gnt_q == SRC_IC) begin
                        gnt = 2'b01;
                    end else begin
                        gnt = 2'b10;
                    end
                end
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
        if (gnt != 2'b00) begin
            last_gnt_d = gnt_to_src(gnt);
        end else begin
            last_gnt_d = last_gnt_q;
        end
    end

    // Last-winner flop; reset to IC so the data cache wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= SRC_IC;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter
//  Shares the single L2 request port between the data cache (DC) and the
//  instruction cache (IC). Round-robin grant, one outstanding transaction,
//  the presented transaction is held on the port until L2 acks it.
//
// Ports:
//  clk, rst_n                          clock, asynchronous active-low reset
//  dc_req_valid/op/addr, dc_req_ready  DC request handshake (ready is comb.)
//  dc_done                             1-cycle pulse when DC transaction acked
//  ic_req_valid/addr, ic_req_ready     IC request handshake (op is READ)
//  ic_done                             1-cycle pulse when IC transaction acked
//  l2_valid/op/addr/src, l2_ack        registered L2 port, src 0=DC 1=IC
//  dc_grants, ic_grants, busy_cycles   statistics counters
//
// Configuration:
//  ARB_STATS_EN  when defined, the statistics counters are implemented
//                (wrapping 32-bit). When undefined the stats ports read 0
//                and no counter flops exist.
// -----------------------------------------------------------------------------
module l2_port_arbiter
    import cache_defs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dc_req_valid,
    input  logic [OP_W-1:0]   dc_req_op,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    output logic              dc_done,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_done,
    output logic              l2_valid,
    output logic [OP_W-1:0]   l2_op,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_src,
    input  logic              l2_ack,
    output logic [31:0]       dc_grants,
    output logic [31:0]       ic_grants,
    output logic [31:0]       busy_cycles
);

    arb_state_e        state_q,    state_d;
    logic              l2_valid_q, l2_valid_d;
    logic [OP_W-1:0]   l2_op_q,    l2_op_d;
    logic [ADDR_W-1:0] l2_addr_q,  l2_addr_d;
    logic              l2_src_q,   l2_src_d;
    logic              dc_done_q,  dc_done_d;
    logic              ic_done_q,  ic_done_d;

    logic [1:0]        gnt_s;
    logic              arb_en_s;
    logic              dc_accept_s;
    logic              ic_accept_s;

    // Arbitration only happens in IDLE, which also enforces one idle cycle
    // between transactions: the cycle that sees l2_ack is still BUSY.
    assign arb_en_s = (state_q == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({ic_req_valid, dc_req_valid}),
        .en    (arb_en_s),
        .gnt   (gnt_s)
    );

    // A grant is only given to a valid requester, so grant == accept.
    assign dc_req_ready = gnt_s[0];
    assign ic_req_ready = gnt_s[1];
    assign dc_accept_s  = dc_req_valid & gnt_s[0];
    assign ic_accept_s  = ic_req_valid & gnt_s[1];

    // FSM next-state and output-register next values.
    always_comb begin
        state_d    = state_q;
        l2_valid_d = l2_valid_q;
        l2_op_d    = l2_op_q;
        l2_addr_d  = l2_addr_q;
        l2_src_d   = l2_src_q;
        dc_done_d  = 1'b0;
        ic_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Any l2_ack seen here is stray and ignored.
                if (dc_accept_s) begin
                    state_d    = ST_BUSY;
                    l2_valid_d = 1'b1;
                    l2_op_d    = dc_req_op;      // reserved 2'b11 passes through
                    l2_addr_d  = dc_req_addr;
                    l2_src_d   = SRC_DC;
                end else if (ic_accept_s) begin
                    state_d    = ST_BUSY;
                    l2_valid_d = 1'b1;
                    l2_op_d    = L2_READ;
                    l2_addr_d  = ic_req_addr;
                    l2_src_d   = SRC_IC;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (l2_ack) begin
                    state_d    = ST_IDLE;
                    l2_valid_d = 1'b0;
                    if (l2_src_q == SRC_IC) begin
                        ic_done_d = 1'b1;
                    end else begin
                        dc_done_d = 1'b1;
                    end
                end else begin
                    state_d    = ST_BUSY;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                l2_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered L2-port / done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            l2_valid_q <= 1'b0;
            l2_op_q    <= {OP_W{1'b0}};
            l2_addr_q  <= {ADDR_W{1'b0}};
            l2_src_q   <= SRC_DC;
            dc_done_q  <= 1'b0;
            ic_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            l2_valid_q <= l2_valid_d;
            l2_op_q    <= l2_op_d;
            l2_addr_q  <= l2_addr_d;
            l2_src_q   <= l2_src_d;
            dc_done_q  <= dc_done_d;
            ic_done_q  <= ic_done_d;
        end
    end

    assign l2_valid = l2_valid_q;
    assign l2_op    = l2_op_q;
    assign l2_addr  = l2_addr_q;
    assign l2_src   = l2_src_q;
    assign dc_done  = dc_done_q;
    assign ic_done  = ic_done_q;

`ifdef ARB_STATS_EN
    logic [31:0] dc_grants_q,   dc_grants_d;
    logic [31:0] ic_grants_q,   ic_grants_d;
    logic [31:0] busy_cycles_q, busy_cycles_d;

    // Statistics counter increments; all wrap naturally at 32 bits.
    always_comb begin
        dc_grants_d   = dc_grants_q;
        ic_grants_d   = ic_grants_q;
        busy_cycles_d = busy_cycles_q;
        if (dc_accept_s) begin
            dc_grants_d = dc_grants_q + 32'd1;
        end else begin
            dc_grants_d = dc_grants_q;
        end
        if (ic_accept_s) begin
            ic_grants_d = ic_grants_q + 32'd1;
        end else begin
            ic_grants_d = ic_grants_q;
        end
        if (l2_valid_q) begin
            busy_cycles_d = busy_cycles_q + 32'd1;
        end else begin
            busy_cycles_d = busy_cycles_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_grants_q   <= 32'd0;
            ic_grants_q   <= 32'd0;
            busy_cycles_q <= 32'd0;
        end else begin
            dc_grants_q   <= dc_grants_d;
            ic_grants_q   <= ic_grants_d;
            busy_cycles_q <= busy_cycles_d;
        end
    end

    assign dc_grants   = dc_grants_q;
    assign ic_grants   = ic_grants_q;
    assign busy_cycles = busy_cycles_q;
`else
    assign dc_grants   = 32'd0;
    assign ic_grants   = 32'd0;
    assign busy_cycles = 32'd0;
`endif

endmodule
